exp_range_reduce: RTL
=====================

Name: exp_range_reduce

Overview:
- Argument-reduction stage directly upstream of the CORDIC e^x block.
- Splits a signed fixed-point x into x = q*ln2 + r with |r| <= ln2/2, so the hyperbolic CORDIC only sees arguments inside its convergence range.
- The downstream consumer computes e^r; a later shifter applies 2^q.
- Sequential: one subtract-and-count step per clock, with valid/ready handshakes on both sides.

Parameters:
- W, 16, data width of x_in and r_out (signed, two's complement).
- FRAC, 12, fractional bits of x_in and r_out (Q4.12 at default).
- QW, 5, width of signed q_out.
- LN2, 2839, ln2 in the x_in format (round(0.693147*2^FRAC)).
- HALF_LN2, 1420, reduction threshold (ceil of LN2/2).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  x_in valid
- in_ready  out  1  block can accept x_in
- x_in  in  W  signed argument, Q4.12
- out_valid  out  1  r_out/q_out valid
- out_ready  in  1  consumer accepts result
- r_out  out  W  signed remainder, same format as x_in
- q_out  out  QW  signed ln2 multiple
- busy  out  1  high in REDUCE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, r_out=0, q_out=0, internal rem/q/sign=0.
- Reset asserted mid-operation aborts at once. The result in flight is discarded with no partial output.
- States:
  - IDLE: in_ready=1. On an edge with in_valid&in_ready: sign<=x_in[W-1]; rem<=|x_in|; q<=0; go to REDUCE.
  - |x_in| for x_in=-2^(W-1) saturates to 2^(W-1)-1 (1-LSB error, accepted).
  - REDUCE: busy=1, in_ready=0. Each edge: if rem>=HALF_LN2 then rem<=rem-LN2 and q<=q+1; else go to DONE.
  - Entering DONE: r_out<=sign?-rem:rem; q_out<=sign?-q:q.
  - DONE: out_valid=1; r_out/q_out held stable. On an edge with out_ready=1, go to IDLE; out_valid drops, outputs keep their last values.
- rem is held as a signed W+1-bit value. The final step may go negative, down to -(LN2-HALF_LN2)=-1419 minimum, and the loop then exits.
- Result range: r_out in [-1419,1419]; q_out in [-12,12] at default parameters.
- Latency: out_valid rises n+1 edges after the accepting edge, where n = number of subtract steps. Minimum 1 (|x|<1420); maximum 13 at defaults.
- out_ready high while not in DONE is ignored. out_valid never depends combinationally on out_ready.
- No new input is accepted until the current result is consumed. There is no back-to-back overlap.

Optional Feature:
- Macro: RR_FAST_STEP_EN.
- With the macro: in REDUCE, if rem>=4*LN2+HALF_LN2 (12776), then rem<=rem-4*LN2 and q<=q+4 in one cycle. Otherwise the single step applies.
- Results are identical with or without the macro; only latency shrinks.
- Without the macro: single step only.

Test Plan:
- x_in=4096 (1.0) -> q_out=1, r_out=1257, out_valid 2 edges after accept. x_in=-4096 -> q_out=-1, r_out=-1257.
- Threshold boundaries:
  - x_in=1419 -> q_out=0, r_out=1419, latency 1.
  - x_in=1420 -> q_out=1, r_out=-1419.
  - x_in=0 -> q_out=0, r_out=0.
- x_in=32767 -> q_out=12, r_out=-1301, latency 13 (7 with RR_FAST_STEP_EN). x_in=-32768 -> q_out=-12, r_out=1301.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout, in_valid pulses ignored. out_ready=1 -> IDLE next edge, in_ready=1.
- Assert rst_n=0 during REDUCE for x_in=32767 -> busy/out_valid drop immediately, outputs 0. After release, x_in=4096 completes normally with q_out=1.
- Random x_in sweep (1000 values) -> q_out*2839+r_out == x_in (saturated) and |r_out|<=1419 on every result.

Source files
------------

// File: rtl/exp_range_reduce.sv
// exp_range_reduce: argument reduction for the CORDIC e^x path.
// Splits signed fixed-point x into x = q*ln2 + r with |r| <= ln2/2. One
// subtract-and-count step is taken per clock, with valid/ready on both sides.
//
// Optional feature: define RR_FAST_STEP_EN to allow a 4*ln2 step per cycle
// while the remainder is large. Results are identical; only latency shrinks.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake for x_in (signed, FRAC fractional bits)
//   out_valid / out_ready output handshake for r_out / q_out
//   r_out                 signed remainder, same format as x_in
//   q_out                 signed multiple of ln2
//   busy                  high while reducing
module exp_range_reduce #(
  parameter int unsigned W        = 16,
  parameter int unsigned FRAC     = 12,
  parameter int unsigned QW       = 5,
  parameter int unsigned LN2      = 2839,
  parameter int unsigned HALF_LN2 = 1420
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  r_out,
  output logic signed [QW-1:0] q_out,
  output logic                 busy
);

  // Parameter sanity: the fractional field must leave room for a sign bit.
  if (FRAC >= W) begin : g_bad_frac
    $error("exp_range_reduce: FRAC must be smaller than W");
  end

  // Remainder carries one extra bit so the last step may go negative.
  localparam logic signed [W:0] Ln2C  = (W+1)'(LN2);
  localparam logic signed [W:0] HalfC = (W+1)'(HALF_LN2);
`ifdef RR_FAST_STEP_EN
  localparam logic signed [W:0] Ln2x4C  = (W+1)'(4 * LN2);
  localparam logic signed [W:0] FastThC = (W+1)'(4 * LN2 + HALF_LN2);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic signed [W:0]     rem_q, rem_d;
  logic signed [QW-1:0]  q_q, q_d;
  logic                  sign_q, sign_d;
  logic signed [W-1:0]   r_out_q, r_out_d;
  logic signed [QW-1:0]  q_out_q, q_out_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic        [W-1:0]   x_abs;

  // |x_in|, saturating the most negative code to the largest positive one.
  always_comb begin
    x_abs = x_in;
    if (x_in[W-1]) begin
      if (x_in == {1'b1, {(W-1){1'b0}}}) x_abs = {1'b0, {(W-1){1'b1}}};
      else                               x_abs = -x_in;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    sign_d      = sign_q;
    r_out_d     = r_out_q;
    q_out_d     = q_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = x_in[W-1];
          rem_d      = {1'b0, x_abs};
          q_d        = '0;
          state_d    = REDUCE;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      REDUCE: begin
`ifdef RR_FAST_STEP_EN
        if (rem_q >= FastThC) begin
          rem_d = rem_q - Ln2x4C;
          q_d   = q_q + QW'(4);
        end else
`endif
        if (rem_q >= HalfC) begin
          rem_d = rem_q - Ln2C;
          q_d   = q_q + QW'(1);
        end else begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          r_out_d     = W'(sign_q ? -rem_q : rem_q);
          q_out_d     = sign_q ? -q_q : q_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      sign_q      <= 1'b0;
      r_out_q     <= '0;
      q_out_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      sign_q      <= sign_d;
      r_out_q     <= r_out_d;
      q_out_q     <= q_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign r_out     = r_out_q;
  assign q_out     = q_out_q;

endmodule
